// File: rtl/i2s_pkg.sv
// Shared types and defaults for the I2S receiver.
package i2s_pkg;

    localparam int DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SKIP  = 2'd1,
        SHIFT = 2'd2,
        DRAIN = 2'd3
    } i2s_state_e;

endpackage

// File: rtl/i2s_rx_bit_sync.sv
// Multi-flop synchronizer for a single asynchronous bit, cleared by async reset.
module bit_sync #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic [DEPTH-1:0] sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[DEPTH-2:0], d_i};
        end
    end

    assign q_o = sync_q[DEPTH-1];

endmodule

// File: rtl/i2s_rx.sv
// I2S slave receiver: deserialises codec ADC data into left/right sample pairs.
// Defining I2S_RX_OVR_COUNT_EN adds a saturating 16-bit overrun_count output.
module i2s_rx
    import i2s_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              aud_bclk,
    input  logic              aud_adclrck,
    input  logic              aud_adcdat,
    output logic [DATA_W-1:0] out_left,
    output logic [DATA_W-1:0] out_right,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              overrun,
`ifdef I2S_RX_OVR_COUNT_EN
    output logic [15:0]       overrun_count,
`endif
    output i2s_state_e        dbg_state
);

    localparam int CNT_W = $clog2(DATA_W);

    logic bclk_s, lrck_s, dat_s;
    logic bclk_prev_q, lrck_prev_q;

    bit_sync #(.DEPTH(2)) u_sync_bclk (.clk(clk), .reset(reset), .d_i(aud_bclk),    .q_o(bclk_s));
    bit_sync #(.DEPTH(2)) u_sync_lrck (.clk(clk), .reset(reset), .d_i(aud_adclrck), .q_o(lrck_s));
    bit_sync #(.DEPTH(2)) u_sync_dat  (.clk(clk), .reset(reset), .d_i(aud_adcdat),  .q_o(dat_s));

    i2s_state_e        state_q;
    logic              chan_q;
    logic              left_ok_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] shift_q;
    logic [DATA_W-1:0] left_q;
    logic [DATA_W-1:0] out_left_q, out_right_q;
    logic              out_valid_q, overrun_q;
    logic [15:0]       ovr_cnt_q;

    logic              bit_evt, lr_edge, lr_fall, last_bit, pair_ok, load;
    logic [DATA_W-1:0] shift_d;

    // lrck moves on bclk falling edges, so its transition is seen before the
    // next bit event; that bit event is the one-slot I2S delay SKIP consumes.
    assign bit_evt  = bclk_s & ~bclk_prev_q;
    assign lr_edge  = lrck_s ^ lrck_prev_q;
    assign lr_fall  = ~lrck_s & lrck_prev_q;
    assign shift_d  = {shift_q[DATA_W-2:0], dat_s};
    assign last_bit = (cnt_q == CNT_W'(DATA_W - 1));
    assign pair_ok  = (state_q == SHIFT) && !lr_edge && bit_evt && last_bit && chan_q && left_ok_q;

    // Handshake: a pair transfers on a clk edge where out_valid && out_ready;
    // until then out_left/out_right are held unchanged.
    assign load = pair_ok && (!out_valid_q || out_ready);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            chan_q      <= 1'b0;
            left_ok_q   <= 1'b0;
            cnt_q       <= '0;
            shift_q     <= '0;
            left_q      <= '0;
            out_left_q  <= '0;
            out_right_q <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            bclk_prev_q <= 1'b0;
            lrck_prev_q <= 1'b0;
            ovr_cnt_q   <= '0;
        end else begin
            bclk_prev_q <= bclk_s;
            lrck_prev_q <= lrck_s;
            overrun_q   <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (lr_fall) begin
                        state_q   <= SKIP;
                        chan_q    <= 1'b0;
                        left_ok_q <= 1'b0;
                    end
                end
                SKIP: begin
                    if (lr_edge) begin
                        chan_q <= lrck_s;
                        if (!lrck_s) left_ok_q <= 1'b0;
                    end else if (bit_evt) begin
                        state_q <= SHIFT;
                        cnt_q   <= '0;
                    end
                end
                SHIFT: begin
                    if (lr_edge) begin
                        state_q   <= SKIP;
                        chan_q    <= lrck_s;
                        left_ok_q <= 1'b0;
                        cnt_q     <= '0;
                    end else if (bit_evt) begin
                        shift_q <= shift_d;
                        cnt_q   <= cnt_q + CNT_W'(1);
                        if (last_bit) begin
                            state_q <= DRAIN;
                            if (!chan_q) begin
                                left_q    <= shift_d;
                                left_ok_q <= 1'b1;
                            end else begin
                                left_ok_q <= 1'b0;
                            end
                        end
                    end
                end
                DRAIN: begin
                    if (lr_edge) begin
                        state_q <= SKIP;
                        chan_q  <= lrck_s;
                        if (!lrck_s) left_ok_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase

            if (load) begin
                out_left_q  <= left_q;
                out_right_q <= shift_d;
                out_valid_q <= 1'b1;
            end else if (pair_ok) begin
                overrun_q <= 1'b1;
                if (ovr_cnt_q != 16'hFFFF) ovr_cnt_q <= ovr_cnt_q + 16'd1;
            end else if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_left  = out_left_q;
    assign out_right = out_right_q;
    assign out_valid = out_valid_q;
    assign overrun   = overrun_q;
    assign dbg_state = state_q;

`ifdef I2S_RX_OVR_COUNT_EN
    assign overrun_count = ovr_cnt_q;
`else
    logic unused_ovr;
    assign unused_ovr = ^ovr_cnt_q;
`endif

endmodule

// File: tb/tb_i2s_rx.sv
// Directed bench for i2s_rx: drives I2S frames, scoreboards output pairs.
module tb_i2s_rx;
  import i2s_pkg::*;

  localparam int W = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic aud_bclk = 1'b0;
  logic aud_adclrck = 1'b1;
  logic aud_adcdat = 1'b0;
  logic out_ready = 1'b1;
  logic [W-1:0] out_left, out_right;
  logic out_valid, overrun;
  i2s_state_e dbg_state;
`ifdef I2S_RX_OVR_COUNT_EN
  logic [15:0] overrun_count;
`endif

  int total = 0;
  int bad = 0;
  logic [2*W-1:0] exp_q[$];
  int ovr_pulses = 0;
  int valid_hi = 0;
  int valid_lo = 0;
  logic prev_valid = 1'b0;
  logic prev_ready = 1'b0;
  logic [W-1:0] prev_l = '0;
  logic [W-1:0] prev_r = '0;

  // clock / reset
  always #10 clk = ~clk;

  i2s_rx #(.DATA_W(W)) dut (
    .clk(clk),
    .reset(reset),
    .aud_bclk(aud_bclk),
    .aud_adclrck(aud_adclrck),
    .aud_adcdat(aud_adcdat),
    .out_left(out_left),
    .out_right(out_right),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .overrun(overrun),
`ifdef I2S_RX_OVR_COUNT_EN
    .overrun_count(overrun_count),
`endif
    .dbg_state(dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic slot_bit(input logic [W-1:0] w, input int k);
    if (k >= 1 && k <= W) return w[W-k];
    return 1'($urandom_range(1, 0));
  endfunction

  // driver: one bclk period, data/lrck change on the falling edge
  task automatic send_bit(input logic lr, input logic d, input bit rdy_pulse);
    @(negedge clk);
    #3;
    aud_bclk = 1'b0;
    aud_adclrck = lr;
    aud_adcdat = d;
    #160 aud_bclk = 1'b1;
    if (rdy_pulse) begin
      #8;
      @(posedge clk);
      #1 out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      #99;
    end else begin
      #147;
    end
  endtask

  task automatic send_frame(input logic [W-1:0] l, input logic [W-1:0] r, input bit push,
                            input int left_slots, input bit rdy_at_commit);
    if (push) exp_q.push_back({l, r});
    for (int k = 0; k < left_slots; k++) send_bit(1'b0, slot_bit(l, k), 1'b0);
    for (int k = 0; k < 32; k++) send_bit(1'b1, slot_bit(r, k), rdy_at_commit && (k == W));
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk);
    #1 out_ready = v;
  endtask

  // monitor + scoreboard
  always @(negedge clk) begin
    if (!reset) begin
      if (overrun) ovr_pulses++;
      if (out_valid) valid_hi++;
      else valid_lo++;
      if (prev_valid && !prev_ready && out_valid) begin
        check("hold_left", 32'(out_left), 32'(prev_l));
        check("hold_right", 32'(out_right), 32'(prev_r));
      end
      if (out_valid && out_ready) begin
        check("pair_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          logic [2*W-1:0] e;
          e = exp_q.pop_front();
          check("pair", {out_left, out_right}, 32'(e));
        end
      end
    end
    prev_valid = out_valid;
    prev_ready = out_ready;
    prev_l = out_left;
    prev_r = out_right;
  end

  initial begin
    #4000000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int v0, o0, lo0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_left", 32'(out_left), 32'd0);
    check("rst_right", 32'(out_right), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
`ifdef I2S_RX_OVR_COUNT_EN
    check("rst_ovr_count", 32'(overrun_count), 32'd0);
`endif
    @(posedge clk);
    #1 reset = 1'b0;
    for (int k = 0; k < 8; k++) send_bit(1'b1, 1'($urandom_range(1, 0)), 1'b0);

    // basic frames, ready held high
    v0 = valid_hi;
    o0 = ovr_pulses;
    send_frame(16'h1234, 16'hABCD, 1'b1, 32, 1'b0);
    send_frame(16'h1234, 16'hABCD, 1'b1, 32, 1'b0);
    check("basic_drained", 32'(exp_q.size()), 32'd0);
    check("basic_valid_cycles", 32'(valid_hi - v0), 32'd2);
    check("basic_no_overrun", 32'(ovr_pulses - o0), 32'd0);

    // backpressure across two frames
    set_ready(1'b0);
    o0 = ovr_pulses;
    send_frame(16'h0001, 16'h0002, 1'b1, 32, 1'b0);
    send_frame(16'h0003, 16'h0004, 1'b0, 32, 1'b0);
    check("ovr_held_valid", 32'(out_valid), 32'd1);
    check("ovr_held_left", 32'(out_left), 32'h0001);
    check("ovr_held_right", 32'(out_right), 32'h0002);
    check("ovr_pulses", 32'(ovr_pulses - o0), 32'd1);
`ifdef I2S_RX_OVR_COUNT_EN
    check("ovr_count", 32'(overrun_count), 32'd1);
`endif
    set_ready(1'b1);
    repeat (3) @(negedge clk);
    check("ovr_drained", 32'(exp_q.size()), 32'd0);
    check("ovr_valid_low", 32'(out_valid), 32'd0);

    // short left word aborts the frame, next frame is clean
    send_frame(16'h0F0F, 16'h3C3C, 1'b0, 8, 1'b0);
    send_frame(16'h7654, 16'h89AB, 1'b1, 32, 1'b0);
    check("abort_drained", 32'(exp_q.size()), 32'd0);

    // start capture mid-right-channel
    set_ready(1'b1);
    reset = 1'b1;
    for (int k = 0; k < 5; k++) send_bit(1'b1, 1'($urandom_range(1, 0)), 1'b0);
    @(posedge clk);
    #1 reset = 1'b0;
    for (int k = 0; k < 12; k++) send_bit(1'b1, 1'($urandom_range(1, 0)), 1'b0);
    send_frame(16'hCAFE, 16'h0BAD, 1'b1, 32, 1'b0);
    check("midright_drained", 32'(exp_q.size()), 32'd0);

    // reset during bit 9 of left with a pair held
    set_ready(1'b0);
    send_frame(16'h5A5A, 16'hA5A5, 1'b0, 32, 1'b0);
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    for (int k = 0; k < 9; k++) send_bit(1'b0, slot_bit(16'h1357, k), 1'b0);
    @(negedge clk);
    #5 reset = 1'b1;
    send_bit(1'b0, slot_bit(16'h1357, 9), 1'b0);
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_left", 32'(out_left), 32'd0);
    check("midrst_right", 32'(out_right), 32'd0);
    check("midrst_overrun", 32'(overrun), 32'd0);
    check("midrst_state", 32'(dbg_state), 32'(IDLE));
`ifdef I2S_RX_OVR_COUNT_EN
    check("midrst_ovr_count", 32'(overrun_count), 32'd0);
`endif
    @(posedge clk);
    #1 reset = 1'b0;
    out_ready = 1'b1;
    for (int k = 10; k < 32; k++) send_bit(1'b0, slot_bit(16'h1357, k), 1'b0);
    for (int k = 0; k < 32; k++) send_bit(1'b1, slot_bit(16'h2468, k), 1'b0);
    send_frame(16'h8000, 16'h7FFF, 1'b1, 32, 1'b0);
    check("postrst_drained", 32'(exp_q.size()), 32'd0);

    // acceptance coinciding with a new commit
    set_ready(1'b0);
    o0 = ovr_pulses;
    send_frame(16'h1111, 16'h2222, 1'b1, 32, 1'b0);
    lo0 = valid_lo;
    send_frame(16'h3333, 16'h4444, 1'b1, 32, 1'b1);
    check("b2b_no_gap", 32'(valid_lo - lo0), 32'd0);
    check("b2b_valid", 32'(out_valid), 32'd1);
    check("b2b_left", 32'(out_left), 32'h3333);
    check("b2b_right", 32'(out_right), 32'h4444);
    check("b2b_no_overrun", 32'(ovr_pulses - o0), 32'd0);
    check("b2b_pending", 32'(exp_q.size()), 32'd1);
    set_ready(1'b1);
    repeat (3) @(negedge clk);
    check("final_drained", 32'(exp_q.size()), 32'd0);
    check("final_valid_low", 32'(out_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
